lfsr_checker: RTL
=================

// Module: lfsr_checker
//
// PURPOSE
//   Downstream consumer of the 8-bit XNOR LFSR (taps 7,3) byte stream. Self-synchronises to
//   the incoming sequence, declares lock, then counts mismatching bytes.
//   Used as the receive-side PRBS checker in link and loopback test paths.
//
// PARAMETERS
//   LOCK_COUNT  4   consecutive predicted matches in HUNT needed to enter LOCKED (>=1)
//   LOSS_COUNT  3   consecutive mismatches in LOCKED that force a return to HUNT (>=1)
//   ERR_W       16  width of the saturating error counter
//
// PORTS
//   clk        in   1      clock, all state on rising edge
//   reset      in   1      asynchronous, active-high; clears all state
//   in_valid   in   1      in_data carries a sample this cycle
//   in_data    in   8      received LFSR byte
//   err_clear  in   1      synchronous clear of err_count
//   locked     out  1      checker is in LOCKED
//   err_pulse  out  1      one-cycle strobe per mismatching byte while LOCKED
//   err_count  out  ERR_W  mismatches since reset/clear, saturates at all-ones
//
// BEHAVIOUR
//   - Prediction: next(r) = {r[6:0], ~(r[7] ^ r[3])}. Reset seed 8'h00; 8'hFF is the lockup value.
//   - Reset (async): state=HUNT, ref=0, have_ref=0, hits=0, miss=0; locked=0, err_pulse=0,
//     err_count=0. Reset mid-lock drops locked immediately; counts lost.
//   - All outputs registered; a valid sample affects outputs on the following clock edge.
//   - in_valid=0: no state change except err_clear; err_pulse=0. Valid gaps are transparent.
//   - HUNT, per valid sample (ref <= in_data always, have_ref <= 1):
//       in_data==8'hFF             -> hits <= 0 (stuck source never locks)
//       have_ref && in_data==next(ref) -> hits+1; if hits+1==LOCK_COUNT -> LOCKED, miss<=0
//       otherwise                  -> hits <= 0
//   - LOCKED, per valid sample: exp = next(ref); ref <= exp (free-running; the received byte is
//     never loaded, so one corrupted byte yields exactly one error)
//       in_data==exp -> miss <= 0
//       mismatch     -> err_pulse=1 next cycle, err_count+1 (saturating), miss+1;
//                       if miss+1==LOSS_COUNT -> HUNT, hits<=0, ref<=in_data, have_ref<=1
//   - Errors are counted only in LOCKED; HUNT mismatches never touch err_count/err_pulse.
//   - err_count saturates at {ERR_W{1'b1}}; further errors still pulse err_pulse.
//   - err_clear with a counted error in the same cycle: err_count <= 1 (error not lost).
//     err_clear with no error: err_count <= 0. err_clear never affects state or lock.
//   - hits/miss counters sized $clog2(max+1); no wrap is possible.
//
// TESTING
//   1 Lock: after reset, drive 00,01,03,07,0F on consecutive valid cycles -> locked=1 the
//     cycle after 0F; err_count=0 throughout.
//   2 Single error: locked, feed 1E,3C,78 with 3C replaced by 3D -> one err_pulse,
//     err_count=1, locked stays 1, following 78,F0,E0 give no further errors.
//   3 Loss: locked, feed AA,55,AA (all mismatches) -> err_count=3, locked=0 after third;
//     then feed a fresh valid run of 5 sequential bytes -> relock.
//   4 Stuck source: 20 valid 8'hFF samples from reset -> locked never asserts, err_count=0.
//   5 Gaps and clear: lock sequence with in_valid low 1-3 cycles between samples -> locks on
//     5th sample; err_clear on the same edge as an error -> err_count=1; alone -> 0.
//   6 Saturation/reset: ERR_W=2, 5 isolated errors -> err_count stays 3; assert reset
//     mid-stream -> locked=0, err_count=0 asynchronously.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker for the 8-bit XNOR LFSR (taps 7,3): hunts for lock, then counts byte errors.
// Latency: a valid sample is reflected on locked/err_pulse/err_count one clock after it is taken.
// Backpressure: none; every in_valid cycle is consumed, gaps in in_valid are transparent.
module lfsr_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             err_clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int HW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(LOSS_COUNT + 1);
    localparam logic [HW-1:0] LOCK_LAST = HW'(LOCK_COUNT);
    localparam logic [MW-1:0] LOSS_LAST = MW'(LOSS_COUNT);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state, state_n;
    logic [7:0]       ref_r, ref_n;
    logic             have_ref, have_ref_n;
    logic [HW-1:0]    hits, hits_n, hits_inc;
    logic [MW-1:0]    miss, miss_n, miss_inc;
    logic             err_hit;
    logic [ERR_W-1:0] err_count_n;
    logic [7:0]       exp_byte;

    function automatic logic [7:0] lfsr_next(input logic [7:0] r);
        return {r[6:0], ~(r[7] ^ r[3])};
    endfunction

    assign exp_byte = lfsr_next(ref_r);
    assign hits_inc = hits + 1'b1;
    assign miss_inc = miss + 1'b1;

    always_comb begin
        state_n     = state;
        ref_n       = ref_r;
        have_ref_n  = have_ref;
        hits_n      = hits;
        miss_n      = miss;
        err_hit     = 1'b0;
        err_count_n = err_count;

        if (in_valid) begin
            if (state == HUNT) begin
                ref_n      = in_data;
                have_ref_n = 1'b1;
                // 8'hFF maps to itself, so a stuck-high source would otherwise look locked
                if (in_data == 8'hFF) begin
                    hits_n = '0;
                end else if (have_ref && in_data == exp_byte) begin
                    if (hits_inc == LOCK_LAST) begin
                        state_n = LOCKED;
                        hits_n  = '0;
                        miss_n  = '0;
                    end else begin
                        hits_n = hits_inc;
                    end
                end else begin
                    hits_n = '0;
                end
            end else begin
                // Free-running reference: a corrupted byte never poisons later predictions
                ref_n = exp_byte;
                if (in_data == exp_byte) begin
                    miss_n = '0;
                end else begin
                    err_hit = 1'b1;
                    if (miss_inc == LOSS_LAST) begin
                        state_n    = HUNT;
                        hits_n     = '0;
                        miss_n     = '0;
                        ref_n      = in_data;
                        have_ref_n = 1'b1;
                    end else begin
                        miss_n = miss_inc;
                    end
                end
            end
        end

        if (err_clear) begin
            err_count_n = err_hit ? ERR_W'(1) : '0;
        end else if (err_hit && err_count != {ERR_W{1'b1}}) begin
            err_count_n = err_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            ref_r     <= 8'h00;
            have_ref  <= 1'b0;
            hits      <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            ref_r     <= ref_n;
            have_ref  <= have_ref_n;
            hits      <= hits_n;
            miss      <= miss_n;
            locked    <= (state_n == LOCKED);
            err_pulse <= err_hit;
            err_count <= err_count_n;
        end
    end

endmodule
